fu_operand_collector: RTL and testbench
=======================================

# fu_operand_collector

Upstream issue stage for the tile's adder functional unit. It accepts one configuration word and then 2·num_inputs operand words over valid/ready streams, in any order, into an indexed slot file. Once every slot is filled it drives the complete operand vector, config word and `on_off` into the adder FU. It holds them until the FU acks or a timeout expires, then returns to idle for the next operation.

## Interface
Parameters:
- `width`, 16, operand word width
- `num_inputs`, 4, FU output lanes; slot count is `total_inputs = 2*num_inputs`
- `ack_timeout`, 16, maximum cycles spent waiting for `fu_ack`; must be ≥ 2

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  reset; one clock; reset is synchronous and active-low
- `cfg_valid`  in  1  config word offered
- `cfg_data`  in  16  config word: [1:0] adder mode, [5:2] dest_info, rest reserved (passed through)
- `cfg_ready`  out  1  config accepted this cycle when `cfg_valid & cfg_ready`
- `opnd_valid`  in  1  operand offered
- `opnd_idx`  in  $clog2(total_inputs)  target slot
- `opnd_data`  in  width  operand value
- `opnd_ready`  out  1  operand accepted when `opnd_valid & opnd_ready`
- `fu_inputs`  out  width × total_inputs  unpacked operand array to FU `inputs`
- `fu_config`  out  16  to FU `config_in`
- `fu_on_off`  out  1  to FU `on_off`
- `fu_ack`  in  1  from FU `ack`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on ack
- `err`  out  1  one-cycle pulse on invalid config or timeout

## Operation
- FSM states: IDLE, COLLECT, WAIT_ACK.
- IDLE: `cfg_ready=1`, `opnd_ready=0`. On the config handshake, modes 0/1/3 latch `cfg_data` into `fu_config`, clear the slot mask and go to COLLECT. Mode 2 is consumed and pulses `err`; the FSM stays in IDLE and `fu_config` is unchanged.
- COLLECT: `opnd_ready=1`, `cfg_ready=0`. Each handshake writes `opnd_data` to slot `opnd_idx` and sets its mask bit.
  - Rewriting a filled slot overwrites the data; the mask is unchanged.
  - When the handshake completes the mask (all `total_inputs` bits set), the next state is WAIT_ACK.
- WAIT_ACK: `fu_on_off=1`; `fu_inputs` and `fu_config` are held stable; both ready outputs are 0. A timeout counter starts at 0 on entry and increments each cycle.
  - `fu_ack` sampled high: next state IDLE, `done` pulses.
  - Otherwise, counter = `ack_timeout-1`: next state IDLE, `err` pulses.
  - Ack and timeout in the same cycle: ack wins.
- Slot data is not cleared between operations; only the mask is cleared.
- `fu_ack` is ignored outside WAIT_ACK.

## Timing
- Reset (`reset` low at a rising edge):
  - state becomes IDLE
  - mask, slots, `fu_config` and counter clear to 0
  - `fu_on_off`, `done`, `err` are 0
- `cfg_ready` and `opnd_ready` are combinationally forced to 0 while `reset` is low.
- Reset mid-operation aborts immediately: `fu_on_off` is low from the first reset edge, and no `done` or `err` is produced.
- Every output except the ready signals is registered.
- Config handshake at edge t puts the FSM in COLLECT at t+1, so the earliest operand handshake is at t+1.
- Final operand handshake at edge t: `fu_on_off` is high from t+1 and `fu_inputs` includes that operand from t+1.
- `fu_ack` high at edge t (while in WAIT_ACK):
  - `fu_on_off` low and `done`=1 from t+1 for exactly one cycle
  - `cfg_ready`=1 from t+1
- Timeout: `fu_on_off` is high for exactly `ack_timeout` cycles, then `err` pulses.
- Minimum operation length is 1 + total_inputs + 1 cycles (config, operands, ack); back-to-back operations need no bubble.

## Structure
- Package `cgra_fu_pkg` holds:
  - enum `adder_mode_t`: ADD_4X16=0, ADD_2X32=1, ADD_1X64=3
  - field constants CFG_MODE_LSB/MSB and CFG_DEST_LSB/MSB
  - FSM `collector_state_t`
  - function `mode_valid()`
- One sub-module, `fu_operand_slots`: the slot array plus mask with write port, clear and `all_full`. The FSM and counter stay in the top.

## Test plan
- Reset with `reset`=0 for 2 cycles -> all `fu_inputs`=0, `fu_on_off`=0, `busy`=0, `cfg_ready`=0 during reset and 1 after.
- Config 0x0000, then operands idx 0..7 = i*1000 in order, FU stub acks 3 cycles after `on_off` rises -> `fu_inputs[k]`=k*1000, `fu_config`=0x0000, `fu_on_off` high 3 cycles, `done` one pulse, back in IDLE.
- Config 0x0035 (mode 1, dest 13), operands in order 7,3,0,5,1,6,2,4 with a rewrite of idx 3 = 0xBEEF before the last operand -> slot 3 = 0xBEEF, `fu_on_off` rises one cycle after idx 4 is accepted.
- Config 0x0002 (invalid) -> `err` one pulse, `busy` stays 0, `fu_config` unchanged.
- Full collect with no ack, `ack_timeout`=16 -> `fu_on_off` high for exactly 16 cycles, then `err` pulse and IDLE.
- `reset` low for one edge while in WAIT_ACK -> `fu_on_off` 0 next cycle, no `done`/`err`, mask empty; a new config is accepted after reset is released.

Source files
------------

// File: rtl/cgra_fu_pkg.sv
// Shared types and config-word field positions for the CGRA adder FU issue path.
package cgra_fu_pkg;

  typedef enum logic [1:0] {
    ADD_4X16 = 2'd0,
    ADD_2X32 = 2'd1,
    ADD_1X64 = 2'd3
  } adder_mode_t;

  localparam int CFG_WIDTH    = 16;
  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_MSB = 1;
  localparam int CFG_DEST_LSB = 2;
  localparam int CFG_DEST_MSB = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_ACK = 2'd2
  } collector_state_t;

  function automatic logic mode_valid(input logic [CFG_WIDTH-1:0] cfg);
    logic [1:0] mode;
    mode = cfg[CFG_MODE_MSB:CFG_MODE_LSB];
    return (mode == ADD_4X16) || (mode == ADD_2X32) || (mode == ADD_1X64);
  endfunction

endpackage

// File: rtl/fu_operand_slots.sv
// Indexed operand slot file with a fill mask; slot data survives a mask clear.
module fu_operand_slots import cgra_fu_pkg::*; #(
  parameter  int width = 16,
  parameter  int depth = 8,
  localparam int idx_w = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [idx_w-1:0] wr_idx,
  input  logic [width-1:0] wr_data,
  output logic [width-1:0] slots [depth],
  output logic             all_full
);

  logic [depth-1:0] mask;
  logic [depth-1:0] mask_next;

  // Full-ness includes the write happening this cycle so the FSM can advance
  // on the completing handshake itself.
  always_comb begin
    mask_next = mask;
    if (wr_en) mask_next[wr_idx] = 1'b1;
    all_full = &mask_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask <= '0;
      for (int i = 0; i < depth; i++) slots[i] <= '0;
    end else if (clear) begin
      mask <= '0;
    end else if (wr_en) begin
      mask          <= mask_next;
      slots[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/fu_operand_collector.sv
// Collects a config word plus 2*num_inputs operands, then presents them to the
// adder FU until it acks or the ack timeout expires.
//
//   state    | meaning
//   IDLE     | waiting for a config word
//   COLLECT  | accepting operands into slots until every slot is filled
//   WAIT_ACK | operands driven to FU with on_off high, waiting for ack/timeout
module fu_operand_collector import cgra_fu_pkg::*; #(
  parameter  int width        = 16,
  parameter  int num_inputs   = 4,
  parameter  int ack_timeout  = 16,
  localparam int total_inputs = 2 * num_inputs,
  localparam int idx_w        = $clog2(total_inputs)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  output logic                 cfg_ready,
  input  logic                 opnd_valid,
  input  logic [idx_w-1:0]     opnd_idx,
  input  logic [width-1:0]     opnd_data,
  output logic                 opnd_ready,
  output logic [width-1:0]     fu_inputs [total_inputs],
  output logic [CFG_WIDTH-1:0] fu_config,
  output logic                 fu_on_off,
  input  logic                 fu_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int cnt_w = $clog2(ack_timeout) + 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(ack_timeout - 1);

  collector_state_t state, next_state;
  logic [cnt_w-1:0] cnt;
  logic cfg_fire, opnd_fire, all_full;
  logic slot_clear, latch_cfg, cfg_bad, ack_done, timeout;

  assign cfg_ready  = reset && (state == IDLE);
  assign opnd_ready = reset && (state == COLLECT);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign opnd_fire  = opnd_valid && opnd_ready;

  fu_operand_slots #(
    .width (width),
    .depth (total_inputs)
  ) u_slots (
    .clk      (clk),
    .reset    (reset),
    .clear    (slot_clear),
    .wr_en    (opnd_fire),
    .wr_idx   (opnd_idx),
    .wr_data  (opnd_data),
    .slots    (fu_inputs),
    .all_full (all_full)
  );

  always_comb begin
    next_state = state;
    slot_clear = 1'b0;
    latch_cfg  = 1'b0;
    cfg_bad    = 1'b0;
    ack_done   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_fire) begin
          if (mode_valid(cfg_data)) begin
            next_state = COLLECT;
            slot_clear = 1'b1;
            latch_cfg  = 1'b1;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (opnd_fire && all_full) next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (fu_ack) begin
          next_state = IDLE;
          ack_done   = 1'b1;
        end else if (cnt == cnt_last) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fu_config <= '0;
      fu_on_off <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= (state == WAIT_ACK) ? cnt + cnt_w'(1) : '0;
      if (latch_cfg) fu_config <= cfg_data;
      fu_on_off <= (next_state == WAIT_ACK);
      busy      <= (next_state != IDLE);
      done      <= ack_done;
      err       <= cfg_bad || timeout;
    end
  end

endmodule

// File: tb/tb_fu_operand_collector.sv
// Directed bench for fu_operand_collector: reset, ordered/unordered collect,
// invalid config, timeout, ack-vs-timeout priority and mid-operation reset.
module tb_fu_operand_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [15:0] cfg_data;
  logic        cfg_ready;
  logic        opnd_valid;
  logic [2:0]  opnd_idx;
  logic [15:0] opnd_data;
  logic        opnd_ready;
  logic [15:0] fu_inputs [8];
  logic [15:0] fu_config;
  logic        fu_on_off;
  logic        fu_ack;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fu_operand_collector #(.width(16), .num_inputs(4), .ack_timeout(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .opnd_valid(opnd_valid), .opnd_idx(opnd_idx), .opnd_data(opnd_data),
    .opnd_ready(opnd_ready),
    .fu_inputs(fu_inputs), .fu_config(fu_config), .fu_on_off(fu_on_off),
    .fu_ack(fu_ack), .busy(busy), .done(done), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic send_opnd(input logic [2:0] idx, input logic [15:0] d);
    opnd_valid = 1'b1;
    opnd_idx   = idx;
    opnd_data  = d;
    step();
    opnd_valid = 1'b0;
  endtask

  task automatic fill_all(input logic [15:0] base);
    for (int i = 0; i < 8; i++) send_opnd(3'(i), base + 16'(i));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (fu_inputs[k] !== 16'h0) begin
        n_bad++; $display("FAIL reset_slot%0d got %h want 0000", k, fu_inputs[k]);
      end
    end
    n_cmp++;
    if ({fu_on_off, busy, cfg_ready, opnd_ready, done, err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 000000",
                        {fu_on_off, busy, cfg_ready, opnd_ready, done, err});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_cfg_ready_after got %b want 1", cfg_ready);
    end
    step();
  endtask

  task automatic test_in_order();
    send_cfg(16'h0000);
    n_cmp++;
    if ({busy, opnd_ready, cfg_ready} !== 3'b110) begin
      n_bad++; $display("FAIL order_collect_flags got %b want 110", {busy, opnd_ready, cfg_ready});
    end
    for (int i = 0; i < 8; i++) send_opnd(3'(i), 16'(i * 1000));
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (fu_on_off !== 1'b1) begin
        n_bad++; $display("FAIL order_on_off_cycle%0d got %b want 1", c, fu_on_off);
      end
      if (c < 2) step();
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (fu_inputs[k] !== 16'(k * 1000)) begin
        n_bad++; $display("FAIL order_slot%0d got %0d want %0d", k, fu_inputs[k], k * 1000);
      end
    end
    n_cmp++;
    if (fu_config !== 16'h0000) begin
      n_bad++; $display("FAIL order_config got %h want 0000", fu_config);
    end
    fu_ack = 1'b1;
    step();
    fu_ack = 1'b0;
    n_cmp++;
    if ({fu_on_off, done, cfg_ready, busy, err} !== 5'b01100) begin
      n_bad++; $display("FAIL order_ack got on/done/crdy/busy/err=%b want 01100",
                        {fu_on_off, done, cfg_ready, busy, err});
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL order_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_out_of_order();
    logic [2:0] seq [7];
    seq = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2};
    send_cfg(16'h0035);
    fu_ack = 1'b1;
    for (int i = 0; i < 7; i++) send_opnd(seq[i], 16'h0100 + 16'(seq[i]));
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL ooo_ack_ignored got done=%b busy=%b want 0 1", done, busy);
    end
    fu_ack = 1'b0;
    send_opnd(3'd3, 16'hBEEF);
    n_cmp++;
    if (fu_on_off !== 1'b0 || opnd_ready !== 1'b1) begin
      n_bad++; $display("FAIL ooo_rewrite_no_fill got on=%b rdy=%b want 0 1", fu_on_off, opnd_ready);
    end
    send_opnd(3'd4, 16'h0104);
    n_cmp++;
    if (fu_on_off !== 1'b1) begin
      n_bad++; $display("FAIL ooo_on_off_rise got %b want 1", fu_on_off);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (fu_inputs[k] !== ((k == 3) ? 16'hBEEF : 16'h0100 + 16'(k))) begin
        n_bad++; $display("FAIL ooo_slot%0d got %h want %h", k, fu_inputs[k],
                          (k == 3) ? 16'hBEEF : 16'h0100 + 16'(k));
      end
    end
    n_cmp++;
    if (fu_config !== 16'h0035 || opnd_ready !== 1'b0) begin
      n_bad++; $display("FAIL ooo_config got %h rdy=%b want 0035 0", fu_config, opnd_ready);
    end
    fu_ack = 1'b1;
    step();
    fu_ack = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || fu_on_off !== 1'b0) begin
      n_bad++; $display("FAIL ooo_ack got done=%b on=%b want 1 0", done, fu_on_off);
    end
  endtask

  task automatic test_invalid_cfg();
    send_cfg(16'h0002);
    n_cmp++;
    if ({err, busy, cfg_ready, opnd_ready} !== 4'b1010) begin
      n_bad++; $display("FAIL inv_flags got err/busy/crdy/ordy=%b want 1010",
                        {err, busy, cfg_ready, opnd_ready});
    end
    n_cmp++;
    if (fu_config !== 16'h0035) begin
      n_bad++; $display("FAIL inv_config got %h want 0035", fu_config);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL inv_err_pulse got err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int guard = 0;
    send_cfg(16'h0003);
    fill_all(16'h2000);
    while (fu_on_off === 1'b1 && guard < 40) begin
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++; $display("FAIL tmo_early_err at high cycle %0d", hi);
      end
      hi++;
      guard++;
      step();
    end
    n_cmp++;
    if (hi != 16) begin
      n_bad++; $display("FAIL tmo_on_cycles got %0d want 16", hi);
    end
    n_cmp++;
    if ({err, done, busy, cfg_ready} !== 4'b1001) begin
      n_bad++; $display("FAIL tmo_end got err/done/busy/crdy=%b want 1001", {err, done, busy, cfg_ready});
    end
    step();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_err_pulse got %b want 0", err);
    end
  endtask

  task automatic test_ack_at_timeout();
    send_cfg(16'h0001);
    fill_all(16'h3000);
    for (int c = 0; c < 15; c++) step();
    n_cmp++;
    if (fu_on_off !== 1'b1) begin
      n_bad++; $display("FAIL ackto_still_on got %b want 1", fu_on_off);
    end
    fu_ack = 1'b1;
    step();
    fu_ack = 1'b0;
    n_cmp++;
    if ({done, err, fu_on_off} !== 3'b100) begin
      n_bad++; $display("FAIL ackto_priority got done/err/on=%b want 100", {done, err, fu_on_off});
    end
  endtask

  task automatic test_reset_mid();
    send_cfg(16'h0000);
    fill_all(16'h4000);
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if ({fu_on_off, done, err, busy, cfg_ready, opnd_ready} !== 6'b0) begin
      n_bad++; $display("FAIL rstmid_flags got %b want 000000",
                        {fu_on_off, done, err, busy, cfg_ready, opnd_ready});
    end
    n_cmp++;
    if (fu_inputs[5] !== 16'h0 || fu_config !== 16'h0) begin
      n_bad++; $display("FAIL rstmid_clear got slot5=%h cfg=%h want 0000 0000", fu_inputs[5], fu_config);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_no_pulse got done=%b err=%b want 0 0", done, err);
    end
    send_cfg(16'h0001);
    n_cmp++;
    if (busy !== 1'b1 || fu_config !== 16'h0001) begin
      n_bad++; $display("FAIL rstmid_new_cfg got busy=%b cfg=%h want 1 0001", busy, fu_config);
    end
    for (int i = 0; i < 7; i++) send_opnd(3'(i), 16'h5000);
    n_cmp++;
    if (fu_on_off !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_mask_empty got on=%b want 0", fu_on_off);
    end
    send_opnd(3'd7, 16'h5007);
    n_cmp++;
    if (fu_on_off !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_refill got on=%b want 1", fu_on_off);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    opnd_valid = 1'b0; opnd_idx = '0; opnd_data = '0; fu_ack = 1'b0;
    #1;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_invalid_cfg();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
